mem_port_arbiter: RTL

- Shares the processor's single memory port between the instruction-fetch (IF) requester and the load/store data (D) requester.
- Uses a req/ack handshake on each requester and a fixed-latency memory with WAIT_CYCLES access time.
- Owns sequencing of every memory access: arbitration, address/data latching, wait-state counting, read-data capture and acknowledge.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch (IF) and load/store (D).
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT consecutive losses to D.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       any_req;
  logic       grant_d;
  logic       if_force;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_port_arbiter: WAIT_CYCLES must be 1..15 and STARVE_LIMIT at least 1");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    any_req   = if_req | d_req;
    grant_d   = d_req & ~if_force;
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant-time latching; address and write data stay frozen for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= 4'd0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_d;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            wait_cnt  <= 4'(WAIT_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (!owner)       if_rdata <= mem_rdata;
            else if (!mem_we) d_rdata  <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign if_force = if_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Counts arbitrations IF lost to D; saturates so the force stays asserted until IF wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!grant_d)
        starve_cnt <= '0;
      else if (if_req && starve_cnt != STARVE_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`else
  assign if_force = 1'b0;
`endif

  assign busy   = (state != IDLE);
  assign mem_en = (state == ACCESS);
  assign if_ack = (state == DONE) && !owner;
  assign d_ack  = (state == DONE) && owner;

endmodule
